// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, ASCII constants and a counter-width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    GRANT  = 2'd2
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request after the one-hot last
// pointer, searching upward with wrap; zero grant when nothing requests.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] last_i,
  output logic [N-1:0] gnt_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  int            last_idx;
  int            cand;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    last_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (last_i[i]) last_idx = i;
    end
    gnt_o = '0;
    found = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int i = 1; i <= N; i++) begin
      cand = (last_idx + i) % N;
      sel  = IW'(cand);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a byte-serial UART emitter.
// Optional UART_ARB_PREFIX_EN emits ASCII '0'+owner before each granted packet.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] EOL_CHAR     = EOL_DEFAULT,
  parameter int         MAX_BURST    = 64,
  parameter int         IDLE_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int TW = cnt_w(IDLE_TIMEOUT);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef UART_ARB_PREFIX_EN
  if (NUM_REQ > 10) begin : g_prefix_range
    $error("UART_ARB_PREFIX_EN needs NUM_REQ <= 10 for single-digit prefixes");
  end
`endif

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] last_q, last_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [TW-1:0]      idle_q, idle_d;
  logic [NUM_REQ-1:0] pick;
  logic [7:0]         req_bytes [NUM_REQ];
  logic [IW-1:0]      own_idx;
  logic [7:0]         own_dat;
  logic               own_vld;
  logic               release_now;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (i_req_valid),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  always_comb begin
    own_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_bytes[k] = i_req_data[8*k +: 8];
      if (grant_q[k]) own_idx = IW'(k);
    end
    own_dat = req_bytes[own_idx];
    own_vld = |(i_req_valid & grant_q);
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_d     = burst_q;
    idle_d      = idle_q;
    release_now = 1'b0;
    o_valid     = 1'b0;
    o_data      = '0;
    o_req_ready = '0;
    case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          grant_d = pick;
`ifdef UART_ARB_PREFIX_EN
          state_d = PREFIX;
`else
          state_d = GRANT;
`endif
        end
      end
`ifdef UART_ARB_PREFIX_EN
      PREFIX: begin
        o_valid = 1'b1;
        o_data  = ASCII_ZERO + 8'(own_idx);
        if (i_ready) state_d = GRANT;
      end
`endif
      GRANT: begin
        o_valid     = own_vld;
        o_data      = own_dat;
        o_req_ready = grant_q & {NUM_REQ{i_ready}};
        // Stalled bytes neither count toward the burst nor toward idleness.
        if (own_vld) begin
          idle_d = '0;
          if (i_ready) begin
            burst_d = burst_q + BW'(1);
            if (own_dat == EOL_CHAR || burst_d == BW'(MAX_BURST)) release_now = 1'b1;
          end
        end else begin
          idle_d = idle_q + TW'(1);
          if (idle_d == TW'(IDLE_TIMEOUT)) release_now = 1'b1;
        end
        if (release_now) begin
          state_d = IDLE;
          last_d  = grant_q;
          grant_d = '0;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= {1'b1, {(NUM_REQ-1){1'b0}}};
      burst_q <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized scoreboard bench for uart_tx_arbiter with a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 8;
`ifdef UART_ARB_PREFIX_EN
  localparam bit PFX = 1'b1;
`else
  localparam bit PFX = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [7:0]     o_data;
  logic           o_valid;
  logic           i_ready;
  logic [N-1:0]   o_grant;
  logic           o_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .EOL_CHAR     (8'h0A),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_data  (req_data),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_grant     (o_grant),
    .o_busy      (o_busy)
  );

  typedef struct packed {
    logic         chk;
    logic [N-1:0] gnt;
    logic         vld;
    logic [7:0]   dat;
    logic [N-1:0] rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("grant", 32'(o_grant), 32'(e.gnt));
          check("busy", 32'(o_busy), 32'(e.gnt != '0));
          check("valid", 32'(o_valid), 32'(e.vld));
          check("req_ready", 32'(req_ready), 32'(e.rdy));
          if (e.vld) check("data", 32'(o_data), 32'(e.dat));
        end
      end
    end
  end

  // Source state
  logic [7:0] s_dat [N];
  logic [N-1:0] s_vld;
  int           gap [N];
  logic [N-1:0] acc;
  logic [7:0]   str_a [3];
  int           a_idx;

  // Reference model: owner index (-1 when idle), last owner, counts.
  int m_own, m_last, m_burst, m_idle;
  bit m_pfx, rel;

  initial begin
    exp_t e;
    str_a = '{8'h41, 8'h42, 8'h0A};
    rst = 1'b1; i_ready = 1'b0; req_valid = '0; req_data = '0;
    s_vld = '0; acc = '0; a_idx = 0;
    for (int k = 0; k < N; k++) begin
      s_dat[k] = 8'h00;
      gap[k] = 0;
    end
    m_own = -1; m_last = N-1; m_burst = 0; m_idle = 0; m_pfx = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          s_vld[k] = 1'b0;
          if (cyc < 40) gap[k] = 0;
          else if ($urandom_range(0, 7) == 0) gap[k] = $urandom_range(6, 14);
          else gap[k] = $urandom_range(0, 2);
        end
        if (!s_vld[k]) begin
          if (gap[k] > 0) gap[k]--;
          else if (cyc >= 2 && cyc < 40) begin
            if (k == 0 && a_idx < 3) begin
              s_vld[0] = 1'b1;
              s_dat[0] = str_a[a_idx];
              a_idx++;
            end
          end else if (cyc >= 40) begin
            s_vld[k] = 1'b1;
            s_dat[k] = ($urandom_range(0, 4) == 0) ? 8'h0A : 8'(8'h41 + $urandom_range(0, 25));
          end
        end
      end
      rst     = (cyc < 2) || (cyc >= 40 && $urandom_range(0, 149) == 0);
      i_ready = (cyc < 40) ? (cyc % 3 == 0) : ($urandom_range(0, 9) < 7);
      req_valid = s_vld;
      for (int k = 0; k < N; k++) req_data[8*k +: 8] = s_dat[k];

      // Expected outputs for this cycle from the current model state.
      e.chk = (cyc != 0);
      e.gnt = '0; e.vld = 1'b0; e.dat = 8'h00; e.rdy = '0;
      if (m_own >= 0) begin
        e.gnt = N'(1) << m_own;
        if (m_pfx) begin
          e.vld = 1'b1;
          e.dat = 8'(8'h30 + m_own);
        end else begin
          e.vld = s_vld[m_own];
          e.dat = s_dat[m_own];
          e.rdy = i_ready ? (N'(1) << m_own) : '0;
        end
      end
      exp_q.push_back(e);
      acc = s_vld & e.rdy;

      // Advance the model.
      rel = 1'b0;
      if (rst) begin
        m_own = -1; m_last = N-1; m_burst = 0; m_idle = 0; m_pfx = 1'b0;
      end else if (m_own < 0) begin
        if (|s_vld) begin
          for (int j = 1; j <= N; j++)
            if (m_own < 0 && s_vld[(m_last + j) % N]) m_own = (m_last + j) % N;
          m_pfx = PFX;
        end
      end else if (m_pfx) begin
        if (i_ready) m_pfx = 1'b0;
      end else if (s_vld[m_own]) begin
        m_idle = 0;
        if (i_ready) begin
          m_burst++;
          if (s_dat[m_own] == 8'h0A || m_burst == MB) rel = 1'b1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) rel = 1'b1;
      end
      if (rel) begin
        m_last = m_own; m_own = -1; m_burst = 0; m_idle = 0;
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
